// File: rtl/exec_div.sv
// exec_div: iterative signed/unsigned integer divide and remainder unit.
// It uses one restoring step per cycle and an IDLE -> CALC -> FIX sequence.
// The unit reports completion with a one-cycle done pulse and wselector=3'b010.
// Optional feature macro: DIV_EARLY_OUT_EN. When it is defined, a leading-zero
// pre-shift of the dividend reduces the number of iterations.

module exec_div #(
  parameter int W    = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            enable,
  input  logic [1:0]      op,
  input  logic [W-1:0]    rs,
  input  logic [W-1:0]    rt,
  input  logic [RD_W-1:0] rd_in,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [W-1:0]    data,
  output logic [RD_W-1:0] rd_out,
  output logic [2:0]      wselector
);

  localparam int            CW       = $clog2(W + 1);
  localparam logic [W-1:0]  MIN_VAL  = {1'b1, {(W-1){1'b0}}};
  localparam logic [2:0]    WSEL_GPR = 3'b010;
  localparam logic [2:0]    WSEL_NONE = 3'b000;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  // Dividend shift register; it collects quotient bits from the LSB end.
  logic [W-1:0]      dvd_q, dvd_d;
  logic [W-1:0]      dvs_q, dvs_d;
  logic [W-1:0]      rem_q, rem_d;
  logic              sel_rem_q, sel_rem_d;
  logic              q_neg_q, q_neg_d;
  logic              r_neg_q, r_neg_d;
  logic [RD_W-1:0]   rd_lat_q, rd_lat_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [W-1:0]      data_q, data_d;
  logic [RD_W-1:0]   rd_out_q, rd_out_d;
  logic [2:0]        wsel_q, wsel_d;

  logic [W-1:0]      rs_mag_s;
  logic [W-1:0]      rt_mag_s;
  logic [W:0]        rem_sh_s;
  logic [W:0]        trial_s;
  logic [W-1:0]      quo_fix_s;
  logic [W-1:0]      rem_fix_s;
  logic              div_zero_s;
  logic              ovf_s;
  logic              start_s;

`ifdef DIV_EARLY_OUT_EN
  logic [CW-1:0]     lz_s;

  // This function counts the leading zero bits of v. The result is W when v is zero.
  function automatic logic [CW-1:0] lzc(input logic [W-1:0] v);
    logic [CW-1:0] n;
    logic          found;
    n     = '0;
    found = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) begin
          found = 1'b1;
        end else begin
          n = n + CW'(1);
        end
      end else begin
        n = n;
      end
    end
    return n;
  endfunction
`endif

  // This block computes the operand magnitudes, the restoring trial step and the sign fix-up values.
  always_comb begin
    rs_mag_s   = (op[0] && rs[W-1]) ? (-rs) : rs;
    rt_mag_s   = (op[0] && rt[W-1]) ? (-rt) : rt;
    div_zero_s = (rt == '0);
    ovf_s      = op[0] && (rs == MIN_VAL) && (rt == '1);
    start_s    = enable && !flush;
    rem_sh_s   = {rem_q, dvd_q[W-1]};
    trial_s    = rem_sh_s - {1'b0, dvs_q};
    quo_fix_s  = q_neg_q ? (-dvd_q) : dvd_q;
    rem_fix_s  = r_neg_q ? (-rem_q) : rem_q;
`ifdef DIV_EARLY_OUT_EN
    lz_s       = lzc(rs_mag_s);
`endif
  end

  // This block computes the next state and the next values of the datapath and output registers.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    sel_rem_d = sel_rem_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    rd_lat_d  = rd_lat_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    data_d    = data_q;
    rd_out_d  = rd_out_q;
    wsel_d    = WSEL_NONE;

    case (state_q)
      S_IDLE: begin
        // The busy output stays high through the done cycle and drops here unless a new operation starts.
        busy_d = 1'b0;
        if (start_s) begin
          busy_d    = 1'b1;
          sel_rem_d = op[1];
          rd_lat_d  = rd_in;
          dvs_d     = rt_mag_s;
          cnt_d     = CW'(W);
          if (div_zero_s) begin
            dvd_d   = '1;
            rem_d   = rs;
            q_neg_d = 1'b0;
            r_neg_d = 1'b0;
            state_d = S_FIX;
          end else if (ovf_s) begin
            dvd_d   = MIN_VAL;
            rem_d   = '0;
            q_neg_d = 1'b0;
            r_neg_d = 1'b0;
            state_d = S_FIX;
`ifdef DIV_EARLY_OUT_EN
          end else if (rs_mag_s == '0) begin
            dvd_d   = '0;
            rem_d   = '0;
            q_neg_d = 1'b0;
            r_neg_d = 1'b0;
            state_d = S_FIX;
          end else begin
            dvd_d   = rs_mag_s << lz_s;
            rem_d   = '0;
            cnt_d   = CW'(W) - lz_s;
            q_neg_d = op[0] & (rs[W-1] ^ rt[W-1]);
            r_neg_d = op[0] & rs[W-1];
            state_d = S_CALC;
          end
`else
          end else begin
            dvd_d   = rs_mag_s;
            rem_d   = '0;
            q_neg_d = op[0] & (rs[W-1] ^ rt[W-1]);
            r_neg_d = op[0] & rs[W-1];
            state_d = S_CALC;
          end
`endif
        end else begin
          state_d = S_IDLE;
        end
      end

      S_CALC: begin
        if (flush) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          // Each cycle shifts in the next dividend bit and keeps the trial subtraction when it is non-negative.
          if (!trial_s[W]) begin
            rem_d = trial_s[W-1:0];
            dvd_d = {dvd_q[W-2:0], 1'b1};
          end else begin
            rem_d = rem_sh_s[W-1:0];
            dvd_d = {dvd_q[W-2:0], 1'b0};
          end
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = S_FIX;
          end else begin
            state_d = S_CALC;
          end
        end
      end

      S_FIX: begin
        if (flush) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          data_d   = sel_rem_q ? rem_fix_s : quo_fix_s;
          rd_out_d = rd_lat_q;
          done_d   = 1'b1;
          wsel_d   = WSEL_GPR;
          busy_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // This block holds the state and the registered outputs, with a synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      sel_rem_q <= 1'b0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      rd_lat_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      data_q    <= '0;
      rd_out_q  <= '0;
      wsel_q    <= WSEL_NONE;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      sel_rem_q <= sel_rem_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      rd_lat_q  <= rd_lat_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      data_q    <= data_d;
      rd_out_q  <= rd_out_d;
      wsel_q    <= wsel_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign data      = data_q;
  assign rd_out    = rd_out_q;
  assign wselector = wsel_q;

endmodule
